// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int unsigned MEM_LAT_MAX = 4;

    // Width needed to hold a value in 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter tracking memory latency; done flags a zero count.
module mem_lat_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(MEM_LAT - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one fixed-latency memory port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned MAX_D_RUN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam int unsigned RUN_W = cnt_width(MAX_D_RUN);

    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    logic             we_q, we_d;
    logic [RUN_W-1:0] run_q, run_d;

    logic lat_done;
    logic resp;
    logic can_issue;
    logic fetch_wins;
    logic if_win;
    logic d_win;

    mem_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat (
        .clk  (clk),
        .rst  (rst),
        .load (if_win | d_win),
        .done (lat_done)
    );

    // Reset gates issue so every output reads 0 while rst is held low.
    always_comb begin
        resp       = (state_q == ARB_BUSY) && lat_done;
        can_issue  = rst && ((state_q == ARB_IDLE) || resp);
        fetch_wins = if_req && (!d_req || (run_q == RUN_W'(MAX_D_RUN)));
        if_win     = can_issue && fetch_wins;
        d_win      = can_issue && d_req && !fetch_wins;
    end

    // Grant, memory drive and response routing.
    always_comb begin
        if_gnt    = if_win;
        d_gnt     = d_win;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (if_win) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
            mem_be   = '1;
        end else if (d_win) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
        end
        if_rvalid = resp && (owner_q == OWN_IF);
        d_rvalid  = resp && (owner_q == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;
        busy      = (state_q == ARB_BUSY);
    end

    // Next state, ownership and data-run tracking.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        run_d   = run_q;
        if (if_win) begin
            state_d = ARB_BUSY;
            owner_d = OWN_IF;
            we_d    = 1'b0;
        end else if (d_win) begin
            state_d = ARB_BUSY;
            owner_d = OWN_D;
            we_d    = d_we;
        end else if (resp) begin
            state_d = ARB_IDLE;
        end
        if (!if_req || if_win) begin
            run_d = '0;
        end else if (d_win && (run_q != RUN_W'(MAX_D_RUN))) begin
            run_d = run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            run_q   <= run_d;
        end
    end

endmodule
